// File: rtl/seg_scan_pkg.sv
// rtl/seg_scan_pkg.sv - shared types and constants for the 7-segment scanner
// Purpose: scan state encoding, digit count, blank codes and digit-index helper.
// Ports: none (package).
package seg_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    GUARD = 2'd2
  } scan_state_t;

  localparam int         NUM_DIGITS = 6;
  localparam logic [7:0] BLANK_CODE = 8'hFF;  // all segments off (active-low)
  localparam logic [7:0] DIG_OFF    = 8'h00;  // no digit enabled

  // Advance the digit index, wrapping after the last digit.
  function automatic logic [2:0] next_digit(input logic [2:0] idx);
    return (idx == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx + 3'd1;
  endfunction

endpackage

// File: rtl/seg_scan_driver_blink_gen.sv
// rtl/seg_scan_driver_blink_gen.sv - blink half-period divider
// Purpose: toggles blink_phase every BLINK_DIV enabled cycles.
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous active-low reset
//   en           in   count enable
//   clear        in   synchronous clear of counter and phase (wins over en)
//   blink_phase  out  1 = blinking digits are currently blanked
module blink_gen #(
  parameter int BLINK_DIV = 25000000,
  parameter int CNT_W     = $clog2(BLINK_DIV + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clear,
  output logic blink_phase
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt         <= '0;
      blink_phase <= 1'b0;
    end else if (clear) begin
      cnt         <= '0;
      blink_phase <= 1'b0;
    end else if (en) begin
      if (cnt == CNT_W'(BLINK_DIV - 1)) begin
        cnt         <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - time-multiplexed six-digit 7-segment scanner
// Purpose: scans six active-low digit codes onto a shared segment bus with
//   one-hot digit enables, blank guard gaps, per-frame snapshot and blink.
// Ports:
//   clk, reset              clock, asynchronous active-low reset
//   disp_en                 display enable; low blanks and parks in IDLE
//   hour/minute/second_tub_control_1/2   digit 0..5 codes (bit7 = DP)
//   blink_mask              bit i set -> digit i blinks
//   seg_out                 segment bus, active-low
//   dig_sel                 one-hot digit enable, [7:6] always 0
module seg_scan_driver
  import seg_scan_pkg::*;
#(
  parameter int SCAN_DIV     = 100000,
  parameter int GUARD_CYCLES = 1000,
  parameter int BLINK_DIV    = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       disp_en,
  input  logic [7:0] hour_tub_control_1,
  input  logic [7:0] hour_tub_control_2,
  input  logic [7:0] minute_tub_control_1,
  input  logic [7:0] minute_tub_control_2,
  input  logic [7:0] second_tub_control_1,
  input  logic [7:0] second_tub_control_2,
  input  logic [5:0] blink_mask,
  output logic [7:0] seg_out,
  output logic [7:0] dig_sel
);

  localparam int MAX_SG  = (SCAN_DIV > GUARD_CYCLES) ? SCAN_DIV : GUARD_CYCLES;
  localparam int MAX_DIV = (MAX_SG > BLINK_DIV) ? MAX_SG : BLINK_DIV;
  localparam int CNT_W   = $clog2(MAX_DIV + 1);

  scan_state_t                      state_q, state_d;
  logic [2:0]                       idx_q, idx_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0][7:0]       snap_q, codes, cur_snap;
  logic [NUM_DIGITS-1:0]            mask_q, cur_mask;
  logic                             load_snap;
  logic                             blink_phase;
  logic [7:0]                       seg_d, dig_d;

  assign codes = {second_tub_control_2, second_tub_control_1,
                  minute_tub_control_2, minute_tub_control_1,
                  hour_tub_control_2,   hour_tub_control_1};

  blink_gen #(
    .BLINK_DIV (BLINK_DIV),
    .CNT_W     (CNT_W)
  ) u_blink (
    .clk         (clk),
    .reset       (reset),
    .en          (disp_en),
    .clear       (~disp_en),
    .blink_phase (blink_phase)
  );

  // State register; outputs are registered from the next-state decode so
  // they line up with the state they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      snap_q  <= {NUM_DIGITS{BLANK_CODE}};
      mask_q  <= '0;
      seg_out <= BLANK_CODE;
      dig_sel <= DIG_OFF;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      if (load_snap) begin
        snap_q <= codes;
        mask_q <= blink_mask;
      end
      seg_out <= seg_d;
      dig_sel <= dig_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    load_snap = 1'b0;
    if (!disp_en) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d   = SHOW;
          idx_d     = '0;
          cnt_d     = '0;
          load_snap = 1'b1;
        end
        SHOW: begin
          if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
            cnt_d = '0;
            if (GUARD_CYCLES == 0) begin
              idx_d     = next_digit(idx_q);
              load_snap = (next_digit(idx_q) == 3'd0);
            end else begin
              state_d = GUARD;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        GUARD: begin
          if (cnt_q == CNT_W'(GUARD_CYCLES - 1)) begin
            state_d   = SHOW;
            cnt_d     = '0;
            idx_d     = next_digit(idx_q);
            load_snap = (next_digit(idx_q) == 3'd0);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output decode. A frame-start edge must show the freshly captured codes,
  // so the snapshot is bypassed on the loading edge.
  always_comb begin
    cur_snap = load_snap ? codes : snap_q;
    cur_mask = load_snap ? blink_mask : mask_q;
    seg_d    = BLANK_CODE;
    dig_d    = DIG_OFF;
    if (state_d == SHOW) begin
      dig_d = 8'b1 << idx_d;
      seg_d = (cur_mask[idx_d] && blink_phase) ? BLANK_CODE : cur_snap[idx_d];
    end
  end

endmodule
